// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame geometry, default bit timing.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;

    // 50 MHz system clock, 115200 baud; shared with the receiver
    localparam int DEF_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and pulses
// bit_tick on the terminal count. clear restarts the period at 0.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = uart_pkg::DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic bit_tick
);
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign bit_tick = en && (cnt_q == LAST);

    // next count: restart on clear, wrap at terminal count, hold when idle
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // counter register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_xmit.sv
// UART transmitter: one byte per write, framed as start, 8 data bits LSB
// first, parity, stop. TxD and TxRDY are driven straight from flops.
module uart_xmit
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        WR,
    input  logic [31:0] Din,
    output logic        TxRDY,
    output logic        TxD
);
    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        par_q, par_d;
    logic        txd_q, txd_d;
    logic        rdy_q, rdy_d;
    logic        baud_clr;
    logic        bit_tick;

    // only the low byte carries data
    logic unused_din_hi;
    assign unused_din_hi = ^Din[31:8];

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (Clock),
        .rst_n   (Reset),
        .clear   (baud_clr),
        .en      (state_q != IDLE),
        .bit_tick(bit_tick)
    );

    // next state plus the value TxD/TxRDY must show once the state changes;
    // computing outputs one cycle ahead keeps them registered
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        txd_d     = txd_q;
        rdy_d     = rdy_q;
        baud_clr  = 1'b0;
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                rdy_d = 1'b1;
                if (WR) begin
                    shift_d   = Din[7:0];
                    par_d     = (^Din[7:0]) ^ PARITY_ODD;
                    bit_cnt_d = '0;
                    baud_clr  = 1'b1;
                    state_d   = START;
                    txd_d     = 1'b0;
                    rdy_d     = 1'b0;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                    txd_d   = shift_q[0];
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                        txd_d   = par_q;
                    end else begin
                        txd_d   = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    state_d = IDLE;
                    txd_d   = 1'b1;
                    rdy_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
                rdy_d   = 1'b1;
            end
        endcase
    end

    // state and datapath registers; reset aborts any frame in flight
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            txd_q     <= 1'b1;
            rdy_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            txd_q     <= txd_d;
            rdy_q     <= rdy_d;
        end
    end

    assign TxD   = txd_q;
    assign TxRDY = rdy_q;

endmodule

// File: tb/tb_uart_xmit.sv
// Bench for uart_xmit: even-parity and odd-parity instances share stimulus;
// expected frames are queued at write time and compared on capture.
module tb_uart_xmit;
    import uart_pkg::*;

    localparam int CPB = 4;
    localparam int FW  = FRAME_BITS * CPB;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        WR    = 1'b0;
    logic [31:0] Din   = '0;
    logic        TxRDY, TxD, TxRDY_o, TxD_o;

    int checks = 0;
    int errors = 0;

    logic [10:0] exp_q[$];

    always #5 Clock = ~Clock;

    uart_xmit #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut (
        .Clock(Clock), .Reset(Reset), .WR(WR), .Din(Din), .TxRDY(TxRDY), .TxD(TxD)
    );

    uart_xmit #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) dut_odd (
        .Clock(Clock), .Reset(Reset), .WR(WR), .Din(Din), .TxRDY(TxRDY_o), .TxD(TxD_o)
    );

    // reference frame: bit 0 = start, 1..8 = data LSB first, 9 = parity, 10 = stop
    function automatic logic [10:0] make_frame(input logic [7:0] d, input bit odd);
        logic [10:0] f;
        int ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[1+i] = d[i];
            if (d[i]) ones++;
        end
        f[9]  = ((ones % 2) == 1) ? ~odd : odd;
        f[10] = 1'b1;
        return f;
    endfunction

    // one frame bit per CPB consecutive samples
    function automatic logic [FW-1:0] expand(input logic [10:0] f);
        logic [FW-1:0] w;
        for (int i = 0; i < FW; i++) w[i] = f[i / CPB];
        return w;
    endfunction

    // capture one frame; call at a negedge. Waits (bounded) for the start bit,
    // then samples TxD on FW negedges and counts cycles with TxRDY low.
    task automatic cap_frame(input bit odd, output logic [FW-1:0] w, output int low,
                             output logic rdy_after, output int gap, output bit to);
        w = '1; low = 0; gap = 0; to = 1'b0; rdy_after = 1'b0;
        while ((odd ? TxD_o : TxD) !== 1'b0) begin
            if (gap >= 200) begin
                to = 1'b1;
                return;
            end
            @(negedge Clock);
            gap++;
        end
        for (int i = 0; i < FW; i++) begin
            w[i] = odd ? TxD_o : TxD;
            if ((odd ? TxRDY_o : TxRDY) === 1'b0) low++;
            @(negedge Clock);
        end
        rdy_after = odd ? TxRDY_o : TxRDY;
    endtask

    // single-cycle write; returns at the negedge after the accepting edge
    task automatic start_write(input logic [31:0] d);
        WR  = 1'b1;
        Din = d;
        exp_q.push_back(make_frame(d[7:0], 1'b0));
        @(negedge Clock);
        WR = 1'b0;
    endtask

    task automatic test_reset();
        int bad = 0;
        Reset = 1'b0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        checks++;
        if (TxD !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", TxD); end
        checks++;
        if (TxRDY !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", TxRDY); end
        Reset = 1'b1;
        repeat (20) begin
            @(negedge Clock);
            if (TxD !== 1'b1 || TxRDY !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL reset_idle: %0d non-idle cycles, want 0", bad); end
    endtask

    task automatic test_odd_ones();
        logic [FW-1:0] w; int low, gap; logic ra; bit to; logic [10:0] e;
        start_write(32'h0000_009D);
        checks++;
        if (TxRDY !== 1'b0) begin errors++; $display("FAIL rdy_drop: got %b want 0", TxRDY); end
        cap_frame(1'b0, w, low, ra, gap, to);
        e = exp_q.pop_front();
        checks++;
        if (to) begin errors++; $display("FAIL frame_9d: timeout waiting for start bit"); end
        else if (w !== expand(e)) begin errors++; $display("FAIL frame_9d: got %h want %h", w, expand(e)); end
        checks++;
        if (low != FW) begin errors++; $display("FAIL busy_len: got %0d want %0d", low, FW); end
        checks++;
        if (ra !== 1'b1) begin errors++; $display("FAIL rdy_return: got %b want 1", ra); end
    endtask

    task automatic test_even_ones();
        logic [FW-1:0] w, wo; int low, lowo, gap, gapo; logic ra, rao; bit to, too;
        logic [10:0] e, eo;
        start_write(32'h0000_0099);
        eo = make_frame(8'h99, 1'b1);
        fork
            cap_frame(1'b0, w, low, ra, gap, to);
            cap_frame(1'b1, wo, lowo, rao, gapo, too);
        join
        e = exp_q.pop_front();
        checks++;
        if (to || w !== expand(e)) begin errors++; $display("FAIL frame_99_even: got %h want %h", w, expand(e)); end
        checks++;
        if (too || wo !== expand(eo)) begin errors++; $display("FAIL frame_99_odd: got %h want %h", wo, expand(eo)); end
        checks++;
        if (lowo != FW || rao !== 1'b1) begin errors++; $display("FAIL busy_len_odd: got %0d/%b want %0d/1", lowo, rao, FW); end
    endtask

    task automatic test_ignored_write();
        logic [FW-1:0] w; int low, gap, bad; logic ra; bit to; logic [10:0] e;
        start_write(32'hFFFF_FF00);
        fork
            cap_frame(1'b0, w, low, ra, gap, to);
            begin
                repeat (10) @(negedge Clock);
                WR = 1'b1; Din = 32'h0000_00FF;
                @(negedge Clock);
                WR = 1'b0;
            end
        join
        e = exp_q.pop_front();
        checks++;
        if (to || w !== expand(e)) begin errors++; $display("FAIL frame_ignore: got %h want %h", w, expand(e)); end
        bad = 0;
        repeat (60) begin
            if (TxD !== 1'b1 || TxRDY !== 1'b1) bad++;
            @(negedge Clock);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL no_second_frame: %0d busy cycles, want 0", bad); end
    endtask

    task automatic test_back_to_back();
        logic [FW-1:0] w1, w2; int low1, low2, gap1, gap2; logic ra1, ra2; bit to1, to2;
        logic [10:0] e1, e2;
        WR = 1'b1; Din = 32'h0000_0055;
        exp_q.push_back(make_frame(8'h55, 1'b0));
        exp_q.push_back(make_frame(8'h55, 1'b0));
        @(negedge Clock);
        cap_frame(1'b0, w1, low1, ra1, gap1, to1);
        fork
            cap_frame(1'b0, w2, low2, ra2, gap2, to2);
            begin
                repeat (10) @(negedge Clock);
                WR = 1'b0;
            end
        join
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        checks++;
        if (to1 || w1 !== expand(e1)) begin errors++; $display("FAIL b2b_frame1: got %h want %h", w1, expand(e1)); end
        checks++;
        if (to2 || w2 !== expand(e2)) begin errors++; $display("FAIL b2b_frame2: got %h want %h", w2, expand(e2)); end
        checks++;
        if (gap2 != 1) begin errors++; $display("FAIL b2b_gap: got %0d want 1", gap2); end
        repeat (5) @(negedge Clock);
    endtask

    task automatic test_reset_mid_frame();
        logic [FW-1:0] w; int low, gap; logic ra; bit to; logic [10:0] e;
        start_write(32'h0000_0000);
        void'(exp_q.pop_front());
        repeat (17) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        checks++;
        if (TxD !== 1'b1) begin errors++; $display("FAIL midreset_txd: got %b want 1", TxD); end
        checks++;
        if (TxRDY !== 1'b1) begin errors++; $display("FAIL midreset_rdy: got %b want 1", TxRDY); end
        Reset = 1'b1;
        @(negedge Clock);
        start_write(32'h0000_00A5);
        cap_frame(1'b0, w, low, ra, gap, to);
        e = exp_q.pop_front();
        checks++;
        if (to || w !== expand(e) || low != FW) begin
            errors++; $display("FAIL frame_a5: got %h/%0d want %h/%0d", w, low, expand(e), FW);
        end
    endtask

    initial begin
        test_reset();
        test_odd_ones();
        repeat (3) @(negedge Clock);
        test_even_ones();
        repeat (3) @(negedge Clock);
        test_ignored_write();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
